// File: rtl/perceptron_accum_act.sv
// perceptron_accum_act: sums N_TERMS unsigned 16-bit perceptron results per
// neuron, then applies a thresholded ReLU, (sum > THRESH) ? sum - THRESH : 0.
// The activation is presented on a valid/ready output port.
// Build option: define ACCUM_SAT_EN to saturate activations above 16'hFFFF.
// Otherwise the low 16 bits are kept (wrap-around).
module perceptron_accum_act #(
  parameter int unsigned N_TERMS = 4,
  parameter logic [15:0] THRESH  = 16'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [3:0]  LAST_CNT = 4'(N_TERMS - 1);
  localparam logic [19:0] THRESH_W = {4'b0000, THRESH};

  state_t      state_q;
  logic [19:0] acc_q;
  logic [3:0]  cnt_q;
  logic [15:0] out_q;

  logic [19:0] sum_d;
  logic [15:0] act_d;

  // Running sum including the current term, plus its activation.
  always_comb begin
    sum_d = acc_q + {4'b0000, in_data};
    act_d = '0;
`ifdef ACCUM_SAT_EN
    if (sum_d > THRESH_W) begin
      if ((sum_d - THRESH_W) > 20'h0FFFF) begin
        act_d = '1;
      end else begin
        act_d = sum_d[15:0] - THRESH;
      end
    end
`else
    // Only the low 16 bits of the difference are needed for wrap-around.
    // The full-width compare still decides the ReLU cut-off.
    if (sum_d > THRESH_W) begin
      act_d = sum_d[15:0] - THRESH;
    end
`endif
  end

  // Control FSM: accumulate terms in ACC, then present the result in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST_CNT) begin
              out_q   <= act_d;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= ST_HOLD;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_q;

endmodule

// File: doc/perceptron_accum_act.md
# perceptron_accum_act

Downstream stage of the 16-bit perceptron datapath. Accepts a stream of unsigned 16-bit perceptron results over a valid/ready handshake and sums a fixed number of terms per neuron. It then applies a thresholded ReLU activation and presents one 16-bit activation per neuron on a valid/ready output port. It turns the purely combinational perceptron result into a registered, flow-controlled neuron output for the next layer.

## Interface
- N_TERMS, 4: number of input terms summed per neuron; legal range 1..16.
- THRESH, 10: unsigned 16-bit threshold subtracted from the sum before activation.
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data carries a valid perceptron result.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  16  unsigned perceptron result.
- out_valid  output  1  out_data holds a completed activation.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  16  unsigned activation result.

## Operation
- Internal state:
  - 20-bit unsigned accumulator `acc`.
  - 4-bit term counter `cnt`.
  - 2-state FSM: ACC and HOLD.
- ACC state:
  - in_ready = 1, out_valid = 0.
  - An input handshake (in_valid && in_ready) adds zero-extended in_data to acc and increments cnt.
  - Cycles with in_valid = 0 leave acc and cnt unchanged. Gaps between terms are allowed.
- Last term: on the handshake where cnt == N_TERMS-1:
  - Compute s = acc + in_data in full 20-bit width.
  - Compute r = (s > THRESH) ? s - THRESH : 0.
  - Register r into out_data, per the width rule below.
  - Clear acc and cnt; go to HOLD.
- HOLD state:
  - in_ready = 0, out_valid = 1.
  - out_data is held stable until out_ready = 1.
  - in_valid is ignored; no term is consumed.
  - On the output handshake (out_valid && out_ready), go to ACC.
- Width rule: r is at most 20 bits. Reduction to 16 bits is set by the configuration macro (see Configuration).
- Arithmetic is unsigned throughout. The 20-bit acc cannot overflow for N_TERMS ≤ 16.
- Reset (asynchronous, at any time, including mid-accumulation or while in HOLD):
  - State goes to ACC.
  - acc = 0, cnt = 0, out_valid = 0, out_data = 0.
  - Partial sums and any pending output are discarded.

## Timing
- Output reset values: in_ready = 1, out_valid = 0, out_data = 0.
- in_ready and out_valid are decoded directly from the FSM state, with no combinational path from in_valid or out_ready.
- Latency: out_valid rises on the clock edge that accepts the last term. It is visible one cycle after that handshake.
- Output handshake:
  - If out_ready is already 1 when out_valid rises, HOLD lasts exactly one cycle.
  - in_ready returns to 1 on the cycle after the output handshake.
- Throughput: one neuron per N_TERMS+1 cycles at best. The HOLD cycle is a bubble, and the block does not overlap input acceptance with output.
- N_TERMS = 1: every accepted term goes directly to HOLD.

## Configuration
- Macro: ACCUM_SAT_EN.
- Defined: if r > 16'hFFFF, out_data = 16'hFFFF (saturate); otherwise out_data = r[15:0].
- Undefined: out_data = r[15:0] always (wrap-around). No saturation logic is synthesized.

## Test plan
- Nominal sum (N_TERMS=4, THRESH=10): send 65, 65, 65, 65 back-to-back, with out_ready held at 1.
  - Expect out_valid one cycle after the 4th handshake, with out_data = 250.
  - Expect in_ready = 0 for exactly one cycle.
- Below threshold: send 2, 2, 2, 2 → out_data = 0 (sum 8 ≤ 10).
- Overflow: send 16'hFFFF four times (s = 20'h3FFFC, r = 20'h3FFF2).
  - With ACCUM_SAT_EN: out_data = 16'hFFFF.
  - Without ACCUM_SAT_EN: out_data = 16'hFFF2.
- Backpressure: complete a neuron (terms 1, 2, 3, 4 → out_data = 0), then hold out_ready = 0 for 3 cycles while pulsing in_valid with data 100.
  - Expect out_valid = 1, out_data unchanged, in_ready = 0, and no term absorbed.
  - Then send 20 × 4 → out_data = 70.
- Input gaps: send 30, idle 2 cycles, 30, idle 1 cycle, 30, 30 → out_data = 110, with acc unchanged during the idle cycles.
- Reset mid-operation:
  - Accept 500 and 500, then pulse rst asynchronously (mid-cycle). Expect all outputs at their reset values immediately.
  - Then send 20 × 4 → out_data = 70, with no residue from before the reset.
  - Repeat with rst asserted during HOLD: out_valid drops at once.
